// File: rtl/vga_pixel_unpack.sv
// Unpacks 128-bit FIFO words into four 24-bit RGB pixels, lane 0 first; pixel, valid and underflow lag pix_req by 1 cycle.
// No backpressure toward the timing generator: a request without a held word yields UNDERFLOW_COLOR and a counted underflow.
module vga_pixel_unpack #(
    parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000,
    parameter int          CNT_W           = 16
) (
    input  logic             vga_clk,
    input  logic             vga_reset_n,
    input  logic             data_fifo_empty,
    input  logic [127:0]     ddr_fifo_rd_data,
    output logic             vga_rd_valid,
    input  logic             pix_req,
    input  logic             frame_start,
    output logic [7:0]       pix_r,
    output logic [7:0]       pix_g,
    output logic [7:0]       pix_b,
    output logic             pix_valid,
    output logic             underflow,
    output logic [CNT_W-1:0] underflow_cnt
);

    logic [127:0]     word_q, word_d;
    logic             word_vld_q, word_vld_d;
    logic [1:0]       lane_q, lane_d;
    logic [23:0]      pix_q, pix_d;
    logic             pix_valid_q, pix_valid_d;
    logic             underflow_q, underflow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;
    logic [23:0]      lane_pix;

    // Reload either into an empty holder or alongside the last pixel of the word, so a full FIFO gives 1 pixel/clk.
    assign pop = vga_reset_n & ~frame_start & ~data_fifo_empty
               & (~word_vld_q | (pix_req & (lane_q == 2'd3)));
    assign vga_rd_valid = pop;

    always_comb begin
        lane_pix = word_q[23:0];
        case (lane_q)
            2'd0: lane_pix = word_q[23:0];
            2'd1: lane_pix = word_q[55:32];
            2'd2: lane_pix = word_q[87:64];
            2'd3: lane_pix = word_q[119:96];
            default: lane_pix = word_q[23:0];
        endcase
    end

    always_comb begin
        word_d      = word_q;
        word_vld_d  = word_vld_q;
        lane_d      = lane_q;
        pix_d       = pix_q;
        pix_valid_d = 1'b0;
        underflow_d = 1'b0;
        cnt_d       = cnt_q;
        if (frame_start) begin
            // A partially consumed word would misalign the new frame; a fresh one is kept.
            if (word_vld_q && (lane_q != 2'd0)) begin
                word_vld_d = 1'b0;
                lane_d     = 2'd0;
            end
        end else begin
            if (pix_req && word_vld_q) begin
                pix_d       = lane_pix;
                pix_valid_d = 1'b1;
                lane_d      = lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    word_vld_d = 1'b0;
                end
            end else if (pix_req) begin
                pix_d       = UNDERFLOW_COLOR;
                underflow_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            if (pop) begin
                word_d     = ddr_fifo_rd_data;
                word_vld_d = 1'b1;
                lane_d     = 2'd0;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            word_q      <= '0;
            word_vld_q  <= 1'b0;
            lane_q      <= 2'd0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            underflow_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            word_q      <= word_d;
            word_vld_q  <= word_vld_d;
            lane_q      <= lane_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            underflow_q <= underflow_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pix_r         = pix_q[23:16];
    assign pix_g         = pix_q[15:8];
    assign pix_b         = pix_q[7:0];
    assign pix_valid     = pix_valid_q;
    assign underflow     = underflow_q;
    assign underflow_cnt = cnt_q;

endmodule

// File: tb/tb_vga_pixel_unpack.sv
// Randomized bench for vga_pixel_unpack against a queue-based pixel model and a bench-side FIFO.
module tb_vga_pixel_unpack;

    localparam int          CNT_W   = 4;
    localparam logic [23:0] UC      = 24'hC35AA5;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             vga_clk = 1'b0;
    logic             vga_reset_n;
    logic             data_fifo_empty;
    logic [127:0]     ddr_fifo_rd_data;
    logic             vga_rd_valid;
    logic             pix_req;
    logic             frame_start;
    logic [7:0]       pix_r, pix_g, pix_b;
    logic             pix_valid;
    logic             underflow;
    logic [CNT_W-1:0] underflow_cnt;

    vga_pixel_unpack #(.UNDERFLOW_COLOR(UC), .CNT_W(CNT_W)) dut (
        .vga_clk          (vga_clk),
        .vga_reset_n      (vga_reset_n),
        .data_fifo_empty  (data_fifo_empty),
        .ddr_fifo_rd_data (ddr_fifo_rd_data),
        .vga_rd_valid     (vga_rd_valid),
        .pix_req          (pix_req),
        .frame_start      (frame_start),
        .pix_r            (pix_r),
        .pix_g            (pix_g),
        .pix_b            (pix_b),
        .pix_valid        (pix_valid),
        .underflow        (underflow),
        .underflow_cnt    (underflow_cnt)
    );

    always #5 vga_clk = ~vga_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Bench FIFO and model: pixels still to be shown from the held word, in display order.
    logic [127:0] fifo_q[$];
    logic [23:0]  m_pix[$];
    logic [23:0]  e_pix;
    logic         e_pv, e_uf;
    int           e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_fifo();
        data_fifo_empty  = (fifo_q.size() == 0);
        ddr_fifo_rd_data = (fifo_q.size() == 0) ? rand_word() : fifo_q[0];
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".pix"},   {8'h0, pix_r, pix_g, pix_b}, {8'h0, e_pix});
        chk({tag, ".valid"}, pix_valid, e_pv);
        chk({tag, ".uflow"}, underflow, e_uf);
        chk({tag, ".cnt"},   underflow_cnt, e_cnt);
    endtask

    // One clock: inputs applied 1 time unit after a rising edge, outputs checked 1 unit after the next.
    task automatic step(input logic req, input logic fs);
        logic         pop;
        logic [127:0] w;
        pix_req     = req;
        frame_start = fs;
        drive_fifo();
        #1;
        pop = vga_reset_n && !fs && (fifo_q.size() > 0)
              && ((m_pix.size() == 0) || (req && m_pix.size() == 1));
        chk("rd_valid", vga_rd_valid, pop);
        e_pv = 1'b0;
        e_uf = 1'b0;
        if (fs) begin
            if (m_pix.size() > 0 && m_pix.size() < 4) m_pix.delete();
        end else if (req) begin
            if (m_pix.size() > 0) begin
                e_pix = m_pix.pop_front();
                e_pv  = 1'b1;
            end else begin
                e_pix = UC;
                e_uf  = 1'b1;
                if (e_cnt < CNT_MAX) e_cnt++;
            end
        end
        if (pop) begin
            w = fifo_q.pop_front();
            for (int k = 0; k < 4; k++) m_pix.push_back(w[32*k +: 24]);
        end
        @(posedge vga_clk);
        #1;
        check_outputs("step");
    endtask

    task automatic reset_pulse();
        pix_req     = 1'b1;
        frame_start = 1'b0;
        #1;
        vga_reset_n = 1'b0;
        m_pix.delete();
        e_pix = '0;
        e_pv  = 1'b0;
        e_uf  = 1'b0;
        e_cnt = 0;
        #1;
        check_outputs("rst_async");
        chk("rst_rd_valid", vga_rd_valid, 1'b0);
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        check_outputs("rst_hold");
        vga_reset_n = 1'b1;
        pix_req     = 1'b0;
    endtask

    initial begin
        logic [127:0] w0;
        vga_reset_n = 1'b0;
        pix_req     = 1'b0;
        frame_start = 1'b0;
        e_pix = '0;
        e_pv  = 1'b0;
        e_uf  = 1'b0;
        e_cnt = 0;
        fifo_q.push_back(rand_word());
        drive_fifo();
        #3;
        check_outputs("reset");
        chk("reset_rd_valid", vga_rd_valid, 1'b0);
        fifo_q.delete();
        drive_fifo();
        @(posedge vga_clk);
        #1;
        vga_reset_n = 1'b1;

        // Back-to-back pixels across a word boundary.
        w0 = {32'hAB030303, 32'hCD020202, 32'hEF010101, 32'h12000000};
        fifo_q.push_back(w0);
        fifo_q.push_back(rand_word());
        step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);

        // Underflows on an empty FIFO.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        chk("uflow_cnt3", underflow_cnt, 3);
        chk("uflow_color", {8'h0, pix_r, pix_g, pix_b}, {8'h0, UC});

        // Discard a partly consumed word, then keep a fresh one across frame_start.
        fifo_q.push_back(rand_word());
        fifo_q.push_back(rand_word());
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        fifo_q.push_back(rand_word());
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);

        // frame_start together with pix_req is ignored as a request.
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Counter saturation.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        chk("uflow_sat", underflow_cnt, CNT_MAX);

        // Reset in the middle of a word.
        fifo_q.push_back(rand_word());
        fifo_q.push_back(rand_word());
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        reset_pulse();
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 99) < 30) fifo_q.push_back(rand_word());
            step($urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
